// File: rtl/ili9341_pkg.sv
// ili9341_pkg: command codes and decode FSM states shared by the ILI9341 serial receiver
package ili9341_pkg;
  localparam logic [7:0] CMD_CASET = 8'h2A;
  localparam logic [7:0] CMD_PASET = 8'h2B;
  localparam logic [7:0] CMD_RAMWR = 8'h2C;
  typedef enum logic [2:0] {IDLE, CASET, PASET, RAMWR, IGNORE} rx_state_t;
endpackage

// File: rtl/ili9341_spi_deser.sv
// ili9341_spi_deser: syncs tft_cs/dc/clk/din to sysclk, shifts MSB-first bytes out as byte_valid/byte_data/byte_dc (abort with ILI_RX_STATS_EN)
module ili9341_spi_deser (
  input  logic       sysclk,
  input  logic       rst,
  input  logic       tft_cs,
  input  logic       tft_dc,
  input  logic       tft_clk,
  input  logic       tft_din,
`ifdef ILI_RX_STATS_EN
  output logic       abort,
`endif
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       byte_dc
);
  logic [1:0] cs_s, dc_s, clk_s, din_s;
  logic       clk_d, cs_d, rise, shift, done;
  logic [2:0] cnt;
  logic [6:0] sr;
  assign rise  = clk_s[1] & ~clk_d;
  assign shift = rise & ~(cs_s[1] & cs_d);
  assign done  = shift & (cnt == 3'd7);
`ifdef ILI_RX_STATS_EN
  assign abort = cs_s[1] & ~shift & (cnt != 3'd0);
`endif
  always_ff @(posedge sysclk or posedge rst)
    if (rst) begin
      cs_s       <= 2'b11;
      dc_s       <= '0;
      clk_s      <= '0;
      din_s      <= '0;
      clk_d      <= 1'b0;
      cs_d       <= 1'b1;
      cnt        <= '0;
      sr         <= '0;
      byte_valid <= 1'b0;
      byte_data  <= '0;
      byte_dc    <= 1'b0;
    end else begin
      cs_s       <= {cs_s[0], tft_cs};
      dc_s       <= {dc_s[0], tft_dc};
      clk_s      <= {clk_s[0], tft_clk};
      din_s      <= {din_s[0], tft_din};
      clk_d      <= clk_s[1];
      cs_d       <= cs_s[1];
      byte_valid <= done;
      cnt        <= shift ? cnt + 3'd1 : cs_s[1] ? 3'd0 : cnt;
      if (shift) sr <= {sr[5:0], din_s[1]};
      if (done) begin
        byte_data <= {sr, din_s[1]};
        byte_dc   <= dc_s[1];
      end
    end
endmodule

// File: rtl/ili9341_spi_rx.sv
// ili9341_spi_rx: ILI9341 panel model decoding CASET/PASET/RAMWR into cmd_valid/cmd_byte and pix_valid/pix_x/pix_y/pix_data (ILI_RX_STATS_EN adds stat_bytes/stat_aborts)
module ili9341_spi_rx
  import ili9341_pkg::*;
#(
  parameter int WIDTH  = 240,
  parameter int HEIGHT = 320
) (
  input  logic                      sysclk,
  input  logic                      rst,
  input  logic                      tft_cs,
  input  logic                      tft_dc,
  input  logic                      tft_clk,
  input  logic                      tft_din,
  output logic                      cmd_valid,
  output logic [7:0]                cmd_byte,
  output logic                      pix_valid,
  output logic [$clog2(WIDTH)-1:0]  pix_x,
  output logic [$clog2(HEIGHT)-1:0] pix_y,
`ifdef ILI_RX_STATS_EN
  output logic [31:0]               stat_bytes,
  output logic [15:0]               stat_aborts,
`endif
  output logic [15:0]               pix_data
);
  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);
  localparam logic [15:0] W = 16'(WIDTH);
  localparam logic [15:0] H = 16'(HEIGHT);
  rx_state_t   state, state_nx;
  logic        bv, bdc, phase;
  logic [7:0]  bd, e_hi, hi;
  logic [1:0]  pcnt;
  logic [15:0] s_stage, sc, ec, sp, ep, x, y;
  logic        is_cmd, is_par, commit, pix_fire, in_win;
  logic [15:0] e_new, e_fix, x_nx, y_nx;
`ifdef ILI_RX_STATS_EN
  logic        abort;
`endif
  ili9341_spi_deser u_deser (
    .sysclk    (sysclk),
    .rst       (rst),
    .tft_cs    (tft_cs),
    .tft_dc    (tft_dc),
    .tft_clk   (tft_clk),
    .tft_din   (tft_din),
`ifdef ILI_RX_STATS_EN
    .abort     (abort),
`endif
    .byte_valid(bv),
    .byte_data (bd),
    .byte_dc   (bdc)
  );
  always_ff @(posedge sysclk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    if (is_cmd)
      state_nx = bd == CMD_CASET ? CASET : bd == CMD_PASET ? PASET : bd == CMD_RAMWR ? RAMWR : IGNORE;
    else if (commit)
      state_nx = IGNORE;
  end
  always_comb begin
    is_cmd   = bv & ~bdc;
    is_par   = bv & bdc & (state == CASET || state == PASET);
    commit   = is_par & (pcnt == 2'd3);
    pix_fire = bv & bdc & (state == RAMWR) & phase;
    e_new    = {e_hi, bd};
    e_fix    = e_new < s_stage ? s_stage : e_new;
    in_win   = (x < W) && (y < H);
    x_nx     = x == ec ? sc : x + 16'd1;
    y_nx     = x != ec ? y : y == ep ? sp : y + 16'd1;
  end
  always_ff @(posedge sysclk or posedge rst)
    if (rst) begin
      cmd_valid <= 1'b0;
      cmd_byte  <= '0;
      pix_valid <= 1'b0;
      pix_x     <= '0;
      pix_y     <= '0;
      pix_data  <= '0;
      pcnt      <= '0;
      phase     <= 1'b0;
      s_stage   <= '0;
      e_hi      <= '0;
      hi        <= '0;
      sc        <= '0;
      ec        <= W - 16'd1;
      sp        <= '0;
      ep        <= H - 16'd1;
      x         <= '0;
      y         <= '0;
    end else begin
      cmd_valid <= is_cmd;
      pix_valid <= pix_fire & in_win;
      if (is_cmd) begin
        cmd_byte <= bd;
        pcnt     <= '0;
        phase    <= 1'b0;
        if (bd == CMD_RAMWR) begin
          x <= sc;
          y <= sp;
        end
      end
      if (is_par) begin
        pcnt <= pcnt + 2'd1;
        if (pcnt == 2'd0) s_stage[15:8] <= bd;
        if (pcnt == 2'd1) s_stage[7:0] <= bd;
        if (pcnt == 2'd2) e_hi <= bd;
      end
      if (commit && state == CASET) begin
        sc <= s_stage;
        ec <= e_fix;
      end
      if (commit && state == PASET) begin
        sp <= s_stage;
        ep <= e_fix;
      end
      if (bv && bdc && state == RAMWR) begin
        phase <= ~phase;
        if (!phase) hi <= bd;
      end
      if (pix_fire) begin
        x <= x_nx;
        y <= y_nx;
        if (in_win) begin
          pix_x    <= x[XW-1:0];
          pix_y    <= y[YW-1:0];
          pix_data <= {hi, bd};
        end
      end
    end
`ifdef ILI_RX_STATS_EN
  always_ff @(posedge sysclk or posedge rst)
    if (rst) begin
      stat_bytes  <= '0;
      stat_aborts <= '0;
    end else begin
      if (bv && !(&stat_bytes)) stat_bytes <= stat_bytes + 32'd1;
      if (abort && !(&stat_aborts)) stat_aborts <= stat_aborts + 16'd1;
    end
`endif
endmodule

// File: tb/tb_ili9341_spi_rx.sv
// tb_ili9341_spi_rx: scoreboard bench driving the ILI9341 serial link at sysclk/4 and checking command and pixel strobes
`timescale 1ns/1ps
module tb_ili9341_spi_rx;
  logic        sysclk = 1'b0, rst = 1'b1;
  logic        tft_cs = 1'b1, tft_dc = 1'b0, tft_clk = 1'b0, tft_din = 1'b0;
  logic        cmd_valid, pix_valid;
  logic [7:0]  cmd_byte, pix_x;
  logic [8:0]  pix_y;
  logic [15:0] pix_data;
`ifdef ILI_RX_STATS_EN
  logic [31:0] stat_bytes;
  logic [15:0] stat_aborts;
`endif
  typedef struct {int x; int y; logic [15:0] d;} pix_t;
  logic [7:0] exp_cmd[$];
  pix_t       exp_pix[$];
  logic [7:0] mon_cmd;
  pix_t       mon_pix;
  int         tests = 0, fails = 0;

  ili9341_spi_rx dut (
    .sysclk   (sysclk),
    .rst      (rst),
    .tft_cs   (tft_cs),
    .tft_dc   (tft_dc),
    .tft_clk  (tft_clk),
    .tft_din  (tft_din),
    .cmd_valid(cmd_valid),
    .cmd_byte (cmd_byte),
    .pix_valid(pix_valid),
    .pix_x    (pix_x),
    .pix_y    (pix_y),
`ifdef ILI_RX_STATS_EN
    .stat_bytes (stat_bytes),
    .stat_aborts(stat_aborts),
`endif
    .pix_data (pix_data)
  );

  always #5 sysclk = ~sysclk;

  always @(negedge sysclk) if (!rst) begin
    if (cmd_valid) begin
      tests++;
      if (exp_cmd.size() == 0) begin
        fails++;
        $display("FAIL cmd_extra: got cmd %h, required no strobe", cmd_byte);
      end else begin
        mon_cmd = exp_cmd.pop_front();
        if (cmd_byte !== mon_cmd) begin
          fails++;
          $display("FAIL cmd_byte: got %h, required %h", cmd_byte, mon_cmd);
        end
      end
    end
    if (pix_valid) begin
      tests++;
      if (exp_pix.size() == 0) begin
        fails++;
        $display("FAIL pix_extra: got (%0d,%0d)=%h, required no strobe", pix_x, pix_y, pix_data);
      end else begin
        mon_pix = exp_pix.pop_front();
        if ({pix_x, pix_y, pix_data} !== {8'(mon_pix.x), 9'(mon_pix.y), mon_pix.d}) begin
          fails++;
          $display("FAIL pix: got (%0d,%0d)=%h, required (%0d,%0d)=%h",
                   pix_x, pix_y, pix_data, mon_pix.x, mon_pix.y, mon_pix.d);
        end
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

  task automatic send_byte(input logic dc, input logic [7:0] b);
    tft_cs = 1'b0;
    tft_dc = dc;
    for (int i = 7; i >= 0; i--) begin
      tft_din = b[i];
      #20 tft_clk = 1'b1;
      #20 tft_clk = 1'b0;
    end
    #40;
  endtask

  task automatic send_pix(input logic [15:0] d);
    send_byte(1'b1, d[15:8]);
    send_byte(1'b1, d[7:0]);
  endtask

  task automatic send_window(input logic [7:0] cmd, input logic [15:0] s, input logic [15:0] e);
    exp_cmd.push_back(cmd);
    send_byte(1'b0, cmd);
    send_pix(s);
    send_pix(e);
  endtask

  task automatic drain(input string name);
    repeat (20) @(negedge sysclk);
    tests++;
    if (exp_cmd.size() != 0 || exp_pix.size() != 0) begin
      fails++;
      $display("FAIL %s_drain: got %0d cmd / %0d pix outstanding, required 0 / 0", name, exp_cmd.size(), exp_pix.size());
      exp_cmd.delete();
      exp_pix.delete();
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge sysclk);
    tests++;
    if ({cmd_valid, cmd_byte, pix_valid, pix_x, pix_y, pix_data} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got %h, required 0", {cmd_valid, cmd_byte, pix_valid, pix_x, pix_y, pix_data});
    end
    rst = 1'b0;
    repeat (5) @(negedge sysclk);
    tests++;
    if ({cmd_valid, pix_valid} !== 2'b00) begin
      fails++;
      $display("FAIL reset_idle: got strobes %b, required 00", {cmd_valid, pix_valid});
    end
  endtask

  task automatic test_single_pixel;
    exp_cmd.push_back(8'h2C);
    exp_pix.push_back('{0, 0, 16'hF800});
    send_byte(1'b0, 8'h2C);
    send_pix(16'hF800);
    drain("single_pixel");
    tests++;
    if (cmd_byte !== 8'h2C) begin
      fails++;
      $display("FAIL cmd_hold: got %h, required 2c", cmd_byte);
    end
  endtask

  task automatic test_window;
    int xs[5] = '{10, 11, 10, 11, 10};
    int ys[5] = '{5, 5, 6, 6, 5};
    send_window(8'h2A, 16'd10, 16'd11);
    send_window(8'h2B, 16'd5, 16'd6);
    exp_cmd.push_back(8'h2C);
    send_byte(1'b0, 8'h2C);
    for (int i = 0; i < 5; i++) begin
      exp_pix.push_back('{xs[i], ys[i], 16'h1000 + 16'(i)});
      send_pix(16'h1000 + 16'(i));
    end
    drain("window");
  endtask

  task automatic test_abort;
    logic [4:0] bits = 5'b10101;
    tft_cs = 1'b0;
    tft_dc = 1'b0;
    for (int i = 4; i >= 0; i--) begin
      tft_din = bits[i];
      #20 tft_clk = 1'b1;
      #20 tft_clk = 1'b0;
    end
    #20 tft_cs = 1'b1;
    #100;
    exp_cmd.push_back(8'h2C);
    send_byte(1'b0, 8'h2C);
    drain("abort");
`ifdef ILI_RX_STATS_EN
    tests++;
    if (stat_aborts !== 16'd1) begin
      fails++;
      $display("FAIL stat_aborts: got %0d, required 1", stat_aborts);
    end
`endif
  endtask

  task automatic test_clip;
    send_window(8'h2A, 16'd0, 16'd250);
    send_window(8'h2B, 16'd0, 16'd319);
    exp_cmd.push_back(8'h2C);
    send_byte(1'b0, 8'h2C);
    for (int i = 0; i < 242; i++) begin
      if (i < 240) exp_pix.push_back('{i, 0, 16'h2000 + 16'(i)});
      send_pix(16'h2000 + 16'(i));
    end
    drain("clip");
  endtask

  task automatic test_half_pixel_abort;
    exp_cmd.push_back(8'h2C);
    send_byte(1'b0, 8'h2C);
    send_byte(1'b1, 8'hAB);
    exp_cmd.push_back(8'h00);
    send_byte(1'b0, 8'h00);
    send_byte(1'b1, 8'h55);
    exp_cmd.push_back(8'h2C);
    send_byte(1'b0, 8'h2C);
    exp_pix.push_back('{0, 0, 16'h1234});
    send_pix(16'h1234);
    drain("half_pixel");
  endtask

  task automatic test_reversed_window;
    send_window(8'h2A, 16'd20, 16'd5);
    send_window(8'h2B, 16'd0, 16'd0);
    exp_cmd.push_back(8'h2C);
    send_byte(1'b0, 8'h2C);
    exp_pix.push_back('{20, 0, 16'hAAAA});
    exp_pix.push_back('{20, 0, 16'hBBBB});
    send_pix(16'hAAAA);
    send_pix(16'hBBBB);
    drain("reversed");
  endtask

  task automatic test_reset_mid;
    send_window(8'h2A, 16'd3, 16'd4);
    exp_cmd.push_back(8'h2B);
    send_byte(1'b0, 8'h2B);
    send_pix(16'h0007);
    drain("reset_mid_pre");
    @(negedge sysclk) rst = 1'b1;
    #1;
    tests++;
    if ({cmd_valid, cmd_byte, pix_valid, pix_x, pix_y, pix_data} !== '0) begin
      fails++;
      $display("FAIL reset_mid_outputs: got %h, required 0", {cmd_valid, cmd_byte, pix_valid, pix_x, pix_y, pix_data});
    end
    repeat (3) @(negedge sysclk);
    rst = 1'b0;
    repeat (3) @(negedge sysclk);
    exp_cmd.push_back(8'h2C);
    send_byte(1'b0, 8'h2C);
    exp_pix.push_back('{0, 0, 16'h5555});
    send_pix(16'h5555);
    drain("reset_mid");
  endtask

  initial begin
    test_reset;
    test_single_pixel;
    test_window;
    test_abort;
    test_clip;
    test_half_pixel_abort;
    test_reversed_window;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
